morse_sequencer: RTL and testbench

Plays one Morse character at a time on the audio path. It takes a 10-bit Morse code word from the CPU's output port through a start/busy/done handshake. It then times dots, dashes and gaps in units of UNIT_TICKS clock cycles, and drives the tone rate word and codec enable that feed the audio DAC and I2C config blocks. It replaces the free-running short/long decomposition with a sequenced, software-controllable player.

---
 rtl/morse_pkg.sv | 30 +++
 rtl/morse_unit_timer.sv | 36 +++
 rtl/morse_sequencer.sv | 142 ++++++++++++++
 tb/tb_morse_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character player.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TONE,
        GAP,
        LGAP,
        WGAP
    } state_e;

    localparam int unsigned DOT_U      = 1;
    localparam int unsigned DASH_U     = 3;
    localparam int unsigned SYM_GAP_U  = 1;
    localparam int unsigned LET_GAP_U  = 3;
    localparam int unsigned WORD_GAP_U = 7;

    localparam int unsigned CODE_W  = 10;
    localparam int unsigned N_MSB   = 9;
    localparam int unsigned N_LSB   = 7;
    localparam int unsigned SYM_MSB = 6;
    localparam int unsigned SYM_W   = 7;
    localparam int unsigned IDX_W   = 3;

    // Timer must hold the longest phase (word space) minus one.
    function automatic int unsigned cnt_width(input int unsigned unit_ticks);
        return $clog2(WORD_GAP_U * unit_ticks + 1);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; zero_c flags the last cycle of the current phase.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/morse_sequencer.sv
// Plays one latched Morse code word: timed dots/dashes, gaps, and a done pulse.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned              UNIT_TICKS = 4,
    parameter int unsigned              RATE_W     = 52,
    parameter logic [RATE_W-1:0]        TONE_RATE  = RATE_W'(1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] morse,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              tone_on,
    output logic              is_dash,
    output logic [RATE_W-1:0] tone_rate,
    output logic              audio_enable
);

    localparam int unsigned CNT_W = cnt_width(UNIT_TICKS);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [IDX_W-1:0]    sym_idx_q, sym_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tone_on_q, tone_on_d;
    logic                is_dash_q, is_dash_d;
    logic                audio_enable_q, audio_enable_d;
    logic [RATE_W-1:0]   tone_rate_q, tone_rate_d;

    logic                timer_load;
    logic [CNT_W-1:0]    timer_val;
    logic                timer_zero_c;
    logic [SYM_W-1:0]    sym_bits;
    logic                sym_dash;
    int unsigned         units;

    morse_unit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero_c   (timer_zero_c)
    );

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        sym_idx_d      = sym_idx_q;
        audio_enable_d = audio_enable_q;
        done_d         = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        code_d         = morse;
                        sym_idx_d      = '0;
                        audio_enable_d = 1'b1;
                        state_d        = (morse[N_MSB:N_LSB] != '0) ? TONE : WGAP;
                    end
                end
                TONE: begin
                    if (timer_zero_c) begin
                        state_d = (({1'b0, sym_idx_q} + 4'd1) < {1'b0, code_q[N_MSB:N_LSB]})
                                  ? GAP : LGAP;
                    end
                end
                GAP: begin
                    if (timer_zero_c) begin
                        sym_idx_d = sym_idx_q + IDX_W'(1);
                        state_d   = TONE;
                    end
                end
                LGAP, WGAP: begin
                    if (timer_zero_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Symbol for the upcoming phase, taken from the code that will be latched.
        sym_bits = code_d[SYM_MSB:0] << sym_idx_d;
        sym_dash = sym_bits[SYM_MSB];

        case (state_d)
            TONE:    units = sym_dash ? DASH_U : DOT_U;
            GAP:     units = SYM_GAP_U;
            LGAP:    units = LET_GAP_U;
            WGAP:    units = WORD_GAP_U;
            default: units = DOT_U;
        endcase

        timer_load  = (state_d != state_q) && (state_d != IDLE);
        timer_val   = CNT_W'(units * UNIT_TICKS - 1);

        busy_d      = (state_d != IDLE);
        tone_on_d   = (state_d == TONE);
        is_dash_d   = tone_on_d && sym_dash;
        tone_rate_d = tone_on_d ? TONE_RATE : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            code_q         <= '0;
            sym_idx_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            tone_on_q      <= 1'b0;
            is_dash_q      <= 1'b0;
            audio_enable_q <= 1'b0;
            tone_rate_q    <= '0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            sym_idx_q      <= sym_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            tone_on_q      <= tone_on_d;
            is_dash_q      <= is_dash_d;
            audio_enable_q <= audio_enable_d;
            tone_rate_q    <= tone_rate_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign tone_on      = tone_on_q;
    assign is_dash      = is_dash_q;
    assign tone_rate    = tone_rate_q;
    assign audio_enable = audio_enable_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with a per-cycle schedule model.
module tb_morse_sequencer;

    localparam int unsigned U      = 4;
    localparam int unsigned RATE_W = 52;
    localparam logic [RATE_W-1:0] RATE = 52'd1000;

    localparam logic [9:0] CH_A    = {3'd2, 7'b0100000};
    localparam logic [9:0] CH_E    = {3'd1, 7'b0000000};
    localparam logic [9:0] CH_T    = {3'd1, 7'b1000000};
    localparam logic [9:0] CH_WORD = {3'd0, 7'b0000000};
    localparam logic [9:0] CH_D7   = {3'd7, 7'b1111111};

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [9:0]        morse;
    logic              busy;
    logic              done;
    logic              tone_on;
    logic              is_dash;
    logic [RATE_W-1:0] tone_rate;
    logic              audio_enable;

    int n_tests = 0;
    int n_fail  = 0;

    morse_sequencer #(.UNIT_TICKS(U), .RATE_W(RATE_W), .TONE_RATE(RATE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .morse        (morse),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .tone_on      (tone_on),
        .is_dash      (is_dash),
        .tone_rate    (tone_rate),
        .audio_enable (audio_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on acceptance, expand the character into a per-cycle list of {tone, dash}.
    logic [1:0] sched[$];
    logic exp_busy = 1'b0, exp_done = 1'b0, exp_tone = 1'b0, exp_dash = 1'b0, exp_aud = 1'b0;

    always @(posedge clk) begin
        logic       was_busy;
        logic       b;
        logic [1:0] e;
        int         n;
        if (reset) begin
            sched.delete();
            {exp_busy, exp_done, exp_tone, exp_dash, exp_aud} = '0;
        end else if (stop) begin
            sched.delete();
            {exp_busy, exp_done, exp_tone, exp_dash} = '0;
        end else begin
            was_busy = exp_busy;
            if (!exp_busy && start) begin
                exp_aud = 1'b1;
                n = int'(morse[9:7]);
                if (n == 0) begin
                    repeat (7 * U) sched.push_back(2'b00);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        b = morse[6 - i];
                        repeat ((b ? 3 : 1) * U) sched.push_back({1'b1, b});
                        if (i < n - 1) repeat (U) sched.push_back(2'b00);
                    end
                    repeat (3 * U) sched.push_back(2'b00);
                end
            end
            if (sched.size() > 0) begin
                e = sched.pop_front();
                exp_busy = 1'b1;
                exp_tone = e[1];
                exp_dash = e[0];
                exp_done = 1'b0;
            end else begin
                exp_done = was_busy;
                {exp_busy, exp_tone, exp_dash} = '0;
            end
        end
        #1;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("tone_on", tone_on, exp_tone);
        check("is_dash", is_dash, exp_dash);
        check("tone_rate", tone_rate, exp_tone ? RATE : '0);
        check("audio_enable", audio_enable, exp_aud);
        check("sym_idx_range", dut.sym_idx_q <= 3'd6, 1'b1);
    end

    // Start a character, measure it until done; optional ignored start and chained start.
    task automatic run_char(input logic [9:0] code, input int poke_at, input logic [9:0] poke_code,
                            input bit chain, input logic [9:0] chain_code,
                            output int busy_n, output int tone_n, output int dash_n, output int lat);
        busy_n = 0; tone_n = 0; dash_n = 0; lat = 0;
        @(negedge clk);
        morse = code;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (busy)    busy_n++;
            if (tone_on) tone_n++;
            if (is_dash) dash_n++;
            if (done) begin
                lat = k;
                if (chain) begin
                    morse = chain_code;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    check("chain_tone_after_done", tone_on, 1'b1);
                end
                break;
            end
            if (k == poke_at) begin
                morse = poke_code;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (lat == 0) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 400; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) check("wait_done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int b, t, d, l, cnt;
        reset = 1'b1; start = 1'b0; stop = 1'b0; morse = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_tone", tone_on, 1'b0);
        check("rst_rate", tone_rate, '0);
        check("rst_aud", audio_enable, 1'b0);
        reset = 1'b0;

        // stop beats start in IDLE
        @(negedge clk);
        morse = CH_A; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("stopstart_busy", busy, 1'b0);
        check("stopstart_aud", audio_enable, 1'b0);

        run_char(CH_A, 0, '0, 1'b0, '0, b, t, d, l);
        check("A_done_at", l, 33);
        check("A_busy", b, 32);
        check("A_tone", t, 16);
        check("A_dash", d, 12);

        run_char(CH_WORD, 0, '0, 1'b0, '0, b, t, d, l);
        check("W_done_at", l, 29);
        check("W_busy", b, 28);
        check("W_tone", t, 0);
        check("W_aud", audio_enable, 1'b1);

        run_char(CH_E, 3, CH_A, 1'b1, CH_E, b, t, d, l);
        check("E_done_at", l, 17);
        check("E_busy", b, 16);
        check("E_tone", t, 4);
        check("E_dash", d, 0);
        wait_done(l);
        check("E2_done_at", l, 17);

        // stop inside the dash of T
        @(negedge clk);
        morse = CH_T; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("T_dash_tone", tone_on, 1'b1);
        check("T_dash_flag", is_dash, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("T_stop_tone", tone_on, 1'b0);
        check("T_stop_busy", busy, 1'b0);
        check("T_stop_rate", tone_rate, '0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("T_stop_nodone", cnt, 0);
        check("T_stop_aud", audio_enable, 1'b1);

        // reset inside a tone
        morse = CH_A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_tone", tone_on, 1'b0);
        check("midrst_dash", is_dash, 1'b0);
        check("midrst_rate", tone_rate, '0);
        check("midrst_aud", audio_enable, 1'b0);
        run_char(CH_E, 0, '0, 1'b0, '0, b, t, d, l);
        check("E3_done_at", l, 17);
        check("E3_busy", b, 16);

        run_char(CH_D7, 0, '0, 1'b0, '0, b, t, d, l);
        check("D7_done_at", l, 121);
        check("D7_busy", b, 120);
        check("D7_tone", t, 84);
        check("D7_dash", d, 84);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
